// File: rtl/mont_mult32.sv
// Bit-serial radix-2 Montgomery multiplier: Result = A*B*2^-WIDTH mod Prime.
// One iteration per clock, then a final conditional subtraction.
module mont_mult32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_sig,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  input  logic [WIDTH-1:0] Prime,
  output logic [WIDTH-1:0] Result,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH+1:0] s_q;
  logic [WIDTH+1:0] s_d;
  logic [WIDTH+1:0] t_sum;
  logic [WIDTH+1:0] t_odd;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;

  // a_q shifts right each iteration, so bit 0 is always a_i
  always_comb begin
    t_sum = s_q + (a_q[0] ? {2'b00, b_q} : '0);
    t_odd = t_sum[0] ? t_sum + {2'b00, p_q} : t_sum;
    s_d   = t_odd >> 1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      s_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (in_sig) begin
            a_q     <= A_i;
            b_q     <= B_i;
            p_q     <= Prime;
            s_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          s_q   <= s_d;
          a_q   <= a_q >> 1;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1))
            state_q <= FIX;
        end
        FIX: begin
          result_q <= (s_q >= {2'b00, p_q})
                    ? WIDTH'(s_q - {2'b00, p_q})
                    : s_q[WIDTH-1:0];
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_mont_mult32.sv
// Self-checking bench for mont_mult32 against a modular-arithmetic model.
// Directed cases plus randomized odd moduli.
module tb_mont_mult32;

  logic        clk;
  logic        reset;
  logic        in_sig;
  logic [31:0] A_i;
  logic [31:0] B_i;
  logic [31:0] Prime;
  logic [31:0] Result;
  logic        busy;
  logic        done;

  int n_cmp;
  int n_err;

  mont_mult32 dut (
    .clk    (clk),
    .reset  (reset),
    .in_sig (in_sig),
    .A_i    (A_i),
    .B_i    (B_i),
    .Prime  (Prime),
    .Result (Result),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A*B mod p, then divide by 2 modulo p, 32 times
  function automatic logic [31:0] ref_mont(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] p
  );
    logic [63:0] x;
    x = (64'(a) * 64'(b)) % 64'(p);
    for (int i = 0; i < 32; i++) begin
      if (x[0]) x = (x + 64'(p)) >> 1;
      else      x = x >> 1;
    end
    return x[31:0];
  endfunction

  // returns after edge k with in_sig already dropped
  task automatic start_op(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] p
  );
    @(negedge clk);
    A_i    = a;
    B_i    = b;
    Prime  = p;
    in_sig = 1'b1;
    @(negedge clk);
    in_sig = 1'b0;
  endtask

  // edges after start until done is seen; -1 on timeout
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 100);
    if (!done) n = -1;
  endtask

  task automatic test_reset;
    reset  = 1'b0;
    in_sig = 1'b0;
    A_i    = '0;
    B_i    = '0;
    Prime  = 32'd3;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (Result !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got R=%h busy=%b done=%b want 0/0/0",
               Result, busy, done);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_to_mont;
    int n;
    start_op(32'h1, 32'h19, 32'hFFFFFFFB);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL to_mont_busy: got %b want 1", busy);
    end
    wait_done(n);
    n_cmp++;
    if (n !== 33) begin
      n_err++;
      $display("FAIL to_mont_latency: got %0d want 33", n);
    end
    n_cmp++;
    if (Result !== 32'h5) begin
      n_err++;
      $display("FAIL to_mont_result: got %h want 00000005", Result);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL to_mont_busy_done: got %b want 0", busy);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || Result !== 32'h5) begin
      n_err++;
      $display("FAIL to_mont_pulse: got done=%b R=%h want 0/00000005",
               done, Result);
    end
  endtask

  task automatic test_from_mont;
    int n;
    start_op(32'h5, 32'h1, 32'hFFFFFFFB);
    wait_done(n);
    n_cmp++;
    if (n !== 33 || Result !== 32'h1) begin
      n_err++;
      $display("FAIL from_mont: got n=%0d R=%h want 33/00000001",
               n, Result);
    end
  endtask

  task automatic test_small_prime;
    int n;
    start_op(32'h3, 32'h4, 32'h17);
    wait_done(n);
    n_cmp++;
    if (n !== 33 || Result !== 32'h1) begin
      n_err++;
      $display("FAIL small_3x4: got n=%0d R=%h want 33/00000001",
               n, Result);
    end
    start_op(32'h16, 32'h16, 32'h17);
    wait_done(n);
    n_cmp++;
    if (n !== 33 || Result !== 32'h2) begin
      n_err++;
      $display("FAIL small_22x22: got n=%0d R=%h want 33/00000002",
               n, Result);
    end
  endtask

  task automatic test_zero_restart;
    int n;
    int extra;
    start_op(32'h0, 32'h12345678, 32'hFFFFFFFB);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 10) begin
        A_i    = 32'h7;
        B_i    = 32'h9;
        Prime  = 32'h17;
        in_sig = 1'b1;
      end else begin
        in_sig = 1'b0;
      end
    end while (!done && n < 100);
    n_cmp++;
    if (n !== 33 || Result !== 32'h0) begin
      n_err++;
      $display("FAIL zero_restart: got n=%0d R=%h want 33/00000000",
               n, Result);
    end
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) extra++;
    end
    n_cmp++;
    if (extra !== 0) begin
      n_err++;
      $display("FAIL zero_restart_extra: got %0d dones want 0", extra);
    end
  endtask

  task automatic test_reset_abort;
    int n;
    int extra;
    start_op(32'h1, 32'h19, 32'hFFFFFFFB);
    repeat (14) @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (Result !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL abort_state: got R=%h busy=%b done=%b want 0/0/0",
               Result, busy, done);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    n_cmp++;
    if (extra !== 0) begin
      n_err++;
      $display("FAIL abort_quiet: got %0d active cycles want 0", extra);
    end
    start_op(32'h1, 32'h19, 32'hFFFFFFFB);
    wait_done(n);
    n_cmp++;
    if (n !== 33 || Result !== 32'h5) begin
      n_err++;
      $display("FAIL abort_rerun: got n=%0d R=%h want 33/00000005",
               n, Result);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    int m;
    int low;
    start_op(32'h5, 32'h1, 32'hFFFFFFFB);
    wait_done(n);
    n_cmp++;
    if (n !== 33 || Result !== 32'h1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_first: got n=%0d R=%h busy=%b want 33/00000001/0",
               n, Result, busy);
    end
    A_i    = 32'h3;
    B_i    = 32'h4;
    Prime  = 32'h17;
    in_sig = 1'b1;
    m   = 0;
    low = 0;
    do begin
      @(negedge clk);
      in_sig = 1'b0;
      m++;
      if (!done && !busy) low++;
    end while (!done && m < 100);
    n_cmp++;
    if (m !== 34 || Result !== 32'h1) begin
      n_err++;
      $display("FAIL b2b_second: got m=%0d R=%h want 34/00000001",
               m, Result);
    end
    n_cmp++;
    if (low !== 0) begin
      n_err++;
      $display("FAIL b2b_busy_gap: got %0d idle cycles want 0", low);
    end
  endtask

  task automatic test_random;
    int n;
    logic [31:0] p;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_r;
    for (int i = 0; i < 24; i++) begin
      if (i % 3 == 0) p = $urandom_range(3, 1000) | 32'h1;
      else            p = $urandom | 32'h1;
      if (p < 32'd3) p = 32'd3;
      a = $urandom % p;
      b = $urandom % p;
      if (i == 1) begin
        a = p - 32'd1;
        b = p - 32'd1;
      end
      exp_r = ref_mont(a, b, p);
      start_op(a, b, p);
      A_i   = $urandom;
      B_i   = $urandom;
      Prime = $urandom;
      wait_done(n);
      n_cmp++;
      if (n !== 33 || Result !== exp_r) begin
        n_err++;
        $display("FAIL random_%0d: p=%h a=%h b=%h got n=%0d R=%h want 33/%h",
                 i, p, a, b, n, Result, exp_r);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset;
    test_to_mont;
    test_from_mont;
    test_small_prime;
    test_zero_restart;
    test_reset_abort;
    test_back_to_back;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
